cpu_phase_ctrl: RTL and testbench
=================================

Name: cpu_phase_ctrl

Overview:
- Multi-cycle sequencer for the 16-bit CPU. Steps each instruction through FETCH / DECODE / EXEC / MEM / WB.
- Generates the datapath strobes around the ALU/shifter.
- Latches the ALU S,Z,C,V condition code into a flag register.
- Resolves branches and handles the memory wait handshake, HLT and restart.

Parameters:
- CNT_W, 16, width of the retired-instruction counter (wraps).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  start/resume pulse. Honoured only in IDLE or HALT.
- instr  in  16  current instruction register contents.
- alu_code  in  4  {S,Z,C,V} from the ALU for the current instruction.
- mem_ready  in  1  memory completes the current access this cycle.
- ir_we  out  1  load instruction register.
- pc_we  out  1  update PC.
- pc_sel  out  1  PC source: 0 = PC+1, 1 = branch target.
- reg_we  out  1  register file write.
- mem_re  out  1  memory read request (fetch or LD).
- mem_we  out  1  memory write request (ST).
- flags  out  4  registered {S,Z,C,V}.
- busy  out  1  high in every state except IDLE and HALT.
- halted  out  1  high in HALT.
- phase  out  3  state encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- retired  out  CNT_W  count of instructions completing WB.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, flags=0, retired=0. All strobes are 0 while reset is asserted and in the following IDLE state.
- Strobes are Moore outputs of state/instr/flags, except ir_we, which also depends on mem_ready.
- Instruction decode:
  - op1 = instr[15:14]; op3 = instr[7:4]; op2 = instr[13:11]; cond = instr[10:8].
  - op1=00 LD; op1=01 ST.
  - op1=11 ALU: op3 = ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, CMP 0101, MOV 0110, SLL 1000, SLR 1001, SRL 1010, SRA 1011, IN 1100, OUT 1101, HLT 1111.
  - op1=10: op2 = LI 000, ADDI 001, SUBI 010, B 100, Bcc 111.
  - Any other encoding is a NOP: PC+1 only.
- IDLE: run=1 -> FETCH.
- FETCH: mem_re=1 every cycle. The FETCH/mem_ready=1 cycle drives ir_we=1 and moves to DECODE; with mem_ready=0, stay in FETCH (wait states are unbounded).
- DECODE: one cycle -> EXEC.
- EXEC: one cycle.
  - Flag load: flags <= alu_code at the end of EXEC for ADD, SUB, AND, OR, XOR, CMP, SLL, SLR, SRL, SRA, ADDI, SUBI. All other instructions leave flags unchanged.
  - Next state: LD/ST -> MEM; all others -> WB.
- MEM: mem_re=1 (LD) or mem_we=1 (ST), held until mem_ready=1, then -> WB. Strobe is held stable while waiting.
- WB: one cycle. pc_we=1 and retired += 1, wrapping mod 2^CNT_W.
  - reg_we=1 for ADD, SUB, AND, OR, XOR, MOV, all shifts, IN, LD, LI, ADDI, SUBI.
  - reg_we=0 for CMP, OUT, ST, B, Bcc, HLT and NOP.
  - pc_sel=1 for B, and for Bcc when its condition holds on the registered flags; otherwise pc_sel=0. Bcc conditions:
    - cond 000 BE: Z.
    - cond 001 BLT: S^V.
    - cond 010 BLE: Z|(S^V).
    - cond 011 BNE: !Z.
    - Other cond: not taken.
  - Next state: HLT -> HALT; all others -> FETCH.
- HALT: all strobes 0, halted=1; run=1 -> FETCH. PC already advanced past the HLT.
- Latency with mem_ready tied high: 4 cycles per non-memory instruction, 5 per LD/ST.
- run outside IDLE/HALT is ignored.
- Reset asserted mid-instruction aborts immediately. No partial writeback completes after reset release.
- Flag hazards:
  - A Bcc uses flags as left by the most recent flag-setting instruction.
  - A flag-setting instruction followed directly by Bcc is resolved correctly, because the flags load in EXEC before the Bcc's WB.

Test Plan:
- Reset then run, mem_ready=1, instr=ADD with alu_code=0100 -> phases 1,2,3,5,1. flags=0100 after EXEC. reg_we and pc_we high in WB with pc_sel=0. retired=1.
- CMP (alu_code=0100) then BE (instr=0xB800) -> CMP has reg_we=0 in WB. BE WB has pc_sel=1, pc_we=1.
- Flags=1000 (S=1,V=0), then BLT (0xB900) -> taken. Same flags, then BLE with Z=0 -> taken. BNE with Z=1 -> not taken (pc_sel=0).
- LD with mem_ready low for 3 cycles in MEM -> mem_re held for 4 cycles, WB follows the ready cycle with reg_we=1. ST equivalent: mem_we held, reg_we=0.
- FETCH with mem_ready low 2 cycles -> ir_we only on the 3rd cycle. MOV with alu_code=1111 -> flags unchanged.
- HLT (op3=1111) -> WB pc_we=1, then halted=1 and busy=0. run pulse -> FETCH. rst_n dropped during MEM -> phase=0 and flags=0 immediately, retired=0.

Source files
------------

// File: rtl/cpu_phase_ctrl.sv
// cpu_phase_ctrl: multi-cycle sequencer for the 16-bit CPU.
// Steps every instruction through FETCH / DECODE / EXEC / [MEM] / WB. It
// generates the datapath strobes, latches the ALU {S,Z,C,V} code into a flag
// register, resolves branches, stalls on the memory ready handshake, and
// handles HLT and restart.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   run        start/resume pulse, honoured only in IDLE or HALT
//   instr      current instruction register contents
//   alu_code   {S,Z,C,V} from the ALU for the current instruction
//   mem_ready  memory completes the current access this cycle
//   ir_we      load instruction register (FETCH with mem_ready)
//   pc_we      update PC (WB)
//   pc_sel     PC source: 0 = PC+1, 1 = branch target
//   reg_we     register file write (WB)
//   mem_re     memory read request (fetch or LD)
//   mem_we     memory write request (ST)
//   flags      registered {S,Z,C,V}
//   busy       high in every state except IDLE and HALT
//   halted     high in HALT
//   phase      state encoding IDLE=0 .. HALT=6
//   retired    count of instructions completing WB (wraps)
module cpu_phase_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [15:0]      instr,
  input  logic [3:0]       alu_code,
  input  logic             mem_ready,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             reg_we,
  output logic             mem_re,
  output logic             mem_we,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             halted,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [3:0]       flags_r;
  logic [CNT_W-1:0] retired_r;

  logic is_ld_s;
  logic is_st_s;
  logic is_hlt_s;
  logic sets_flags_s;
  logic reg_write_s;
  logic taken_s;

  // instr[3:0] carries register fields that only the datapath uses
  logic unused_s;
  assign unused_s = ^instr[3:0];

  // Instructions whose ALU result updates {S,Z,C,V}
  function automatic logic dec_sets_flags(input logic [15:0] ins);
    logic r;
    r = 1'b0;
    case (ins[15:14])
      2'b11: begin
        case (ins[7:4])
          4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
          4'b1000, 4'b1001, 4'b1010, 4'b1011: r = 1'b1;
          default: r = 1'b0;
        endcase
      end
      2'b10: begin
        case (ins[13:11])
          3'b001, 3'b010: r = 1'b1;
          default:        r = 1'b0;
        endcase
      end
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Instructions that write a destination register in WB
  function automatic logic dec_reg_write(input logic [15:0] ins);
    logic r;
    r = 1'b0;
    case (ins[15:14])
      2'b00: r = 1'b1;
      2'b11: begin
        case (ins[7:4])
          4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0110,
          4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100: r = 1'b1;
          default: r = 1'b0;
        endcase
      end
      2'b10: begin
        case (ins[13:11])
          3'b000, 3'b001, 3'b010: r = 1'b1;
          default:                r = 1'b0;
        endcase
      end
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Branch resolution against the registered flags {S,Z,C,V}
  function automatic logic dec_taken(input logic [15:0] ins, input logic [3:0] fl);
    logic r;
    logic s_xor_v;
    r       = 1'b0;
    s_xor_v = fl[3] ^ fl[0];
    if (ins[15:14] == 2'b10 && ins[13:11] == 3'b100) begin
      r = 1'b1;
    end else if (ins[15:14] == 2'b10 && ins[13:11] == 3'b111) begin
      case (ins[10:8])
        3'b000:  r = fl[2];
        3'b001:  r = s_xor_v;
        3'b010:  r = fl[2] | s_xor_v;
        3'b011:  r = ~fl[2];
        default: r = 1'b0;
      endcase
    end else begin
      r = 1'b0;
    end
    return r;
  endfunction

  // Instruction decode of the current instruction register
  always_comb begin
    is_ld_s      = (instr[15:14] == 2'b00);
    is_st_s      = (instr[15:14] == 2'b01);
    is_hlt_s     = (instr[15:14] == 2'b11) && (instr[7:4] == 4'b1111);
    sets_flags_s = dec_sets_flags(instr);
    reg_write_s  = dec_reg_write(instr);
    taken_s      = dec_taken(instr, flags_r);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and strobe generation
  always_comb begin
    state_nxt_s = state_r;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = 1'b0;
    reg_we      = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    busy        = 1'b1;
    halted      = 1'b0;
    case (state_r)
      IDLE: begin
        busy = 1'b0;
        if (run) begin
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FETCH: begin
        mem_re = 1'b1;
        // wait states are unbounded; the IR only loads on the ready cycle
        if (mem_ready) begin
          ir_we       = 1'b1;
          state_nxt_s = DECODE;
        end else begin
          state_nxt_s = FETCH;
        end
      end
      DECODE: begin
        state_nxt_s = EXEC;
      end
      EXEC: begin
        if (is_ld_s || is_st_s) begin
          state_nxt_s = MEM;
        end else begin
          state_nxt_s = WB;
        end
      end
      MEM: begin
        // request held stable until the memory accepts it
        mem_re = is_ld_s;
        mem_we = is_st_s;
        if (mem_ready) begin
          state_nxt_s = WB;
        end else begin
          state_nxt_s = MEM;
        end
      end
      WB: begin
        pc_we  = 1'b1;
        reg_we = reg_write_s;
        pc_sel = taken_s;
        if (is_hlt_s) begin
          state_nxt_s = HALT;
        end else begin
          state_nxt_s = FETCH;
        end
      end
      HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
        if (run) begin
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = HALT;
        end
      end
      default: begin
        busy        = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Condition-code register; loads at the end of EXEC so a following
  // Bcc already sees the new flags in its own WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r <= 4'b0000;
    end else if (state_r == EXEC && sets_flags_s) begin
      flags_r <= alu_code;
    end else begin
      flags_r <= flags_r;
    end
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_r <= {CNT_W{1'b0}};
    end else if (state_r == WB) begin
      retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      retired_r <= retired_r;
    end
  end

  assign flags   = flags_r;
  assign phase   = state_r;
  assign retired = retired_r;

endmodule

// File: tb/tb_cpu_phase_ctrl.sv
// Directed bench for cpu_phase_ctrl: every cycle pushes its expected
// phase/strobes/flags/retired onto a scoreboard queue and pops it against
// the DUT outputs sampled 1 ns after the falling edge.
module tb_cpu_phase_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [15:0] instr;
  logic [3:0]  alu_code;
  logic        mem_ready;
  logic        ir_we, pc_we, pc_sel, reg_we, mem_re, mem_we;
  logic [3:0]  flags;
  logic        busy, halted;
  logic [2:0]  phase;
  logic [15:0] retired;

  cpu_phase_ctrl #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .instr     (instr),
    .alu_code  (alu_code),
    .mem_ready (mem_ready),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_sel    (pc_sel),
    .reg_we    (reg_we),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .flags     (flags),
    .busy      (busy),
    .halted    (halted),
    .phase     (phase),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  // strobe vector order: {ir_we, pc_we, pc_sel, reg_we, mem_re, mem_we, busy, halted}
  localparam logic [7:0] S_IDLE    = 8'b0000_0000;
  localparam logic [7:0] S_FETCH   = 8'b1000_1010;
  localparam logic [7:0] S_FETCH_W = 8'b0000_1010;
  localparam logic [7:0] S_BUSY    = 8'b0000_0010;
  localparam logic [7:0] S_MEM_LD  = 8'b0000_1010;
  localparam logic [7:0] S_MEM_ST  = 8'b0000_0110;
  localparam logic [7:0] S_WB_REG  = 8'b0101_0010;
  localparam logic [7:0] S_WB_NONE = 8'b0100_0010;
  localparam logic [7:0] S_WB_TAKE = 8'b0110_0010;
  localparam logic [7:0] S_HALT    = 8'b0000_0001;

  typedef struct {
    string       tag;
    logic [14:0] obs;
    logic [15:0] ret;
  } exp_t;

  exp_t        sb_q[$];
  int          compared   = 0;
  int          mismatched = 0;
  logic [3:0]  fl_m;
  logic [15:0] ret_m;

  // One cycle: push expectation, sample 1 ns later, pop and compare.
  task automatic cyc(input string tag, input logic [2:0] ph, input logic [7:0] st);
    exp_t        e;
    logic [14:0] got;
    e.tag = tag;
    e.obs = {ph, st, fl_m};
    e.ret = ret_m;
    sb_q.push_back(e);
    #1;
    got = {phase, ir_we, pc_we, pc_sel, reg_we, mem_re, mem_we, busy, halted, flags};
    e = sb_q.pop_front();
    compared++;
    assert (got === e.obs) else begin
      mismatched++;
      $error("FAIL %s: observed phase/strobes/flags=%b expected %b", e.tag, got, e.obs);
    end
    compared++;
    assert (retired === e.ret) else begin
      mismatched++;
      $error("FAIL %s.retired: observed %0d expected %0d", e.tag, retired, e.ret);
    end
    @(negedge clk);
  endtask

  // Whole instruction starting in FETCH. mkind: 0 none, 1 LD, 2 ST.
  task automatic do_instr(input string tag, input logic [15:0] ins, input logic [3:0] alu,
                          input bit sets, input int fwait, input int mkind, input int mwait,
                          input logic [7:0] wb_st);
    instr    = ins;
    alu_code = alu;
    for (int i = 0; i < fwait; i++) begin
      mem_ready = 1'b0;
      cyc({tag, ".fetch_wait"}, 3'd1, S_FETCH_W);
    end
    mem_ready = 1'b1;
    cyc({tag, ".fetch"}, 3'd1, S_FETCH);
    cyc({tag, ".decode"}, 3'd2, S_BUSY);
    cyc({tag, ".exec"}, 3'd3, S_BUSY);
    if (sets) fl_m = alu;
    if (mkind != 0) begin
      for (int i = 0; i < mwait; i++) begin
        mem_ready = 1'b0;
        cyc({tag, ".mem_wait"}, 3'd4, (mkind == 1) ? S_MEM_LD : S_MEM_ST);
      end
      mem_ready = 1'b1;
      cyc({tag, ".mem_ready"}, 3'd4, (mkind == 1) ? S_MEM_LD : S_MEM_ST);
    end
    cyc({tag, ".wb"}, 3'd5, wb_st);
    ret_m = ret_m + 16'd1;
  endtask

  initial begin
    fl_m      = 4'b0000;
    ret_m     = 16'd0;
    rst_n     = 1'b0;
    run       = 1'b0;
    mem_ready = 1'b1;
    instr     = 16'h0000;
    alu_code  = 4'b0000;

    cyc("reset", 3'd0, S_IDLE);
    rst_n = 1'b1;
    cyc("idle", 3'd0, S_IDLE);
    run = 1'b1;
    cyc("idle_run", 3'd0, S_IDLE);
    run = 1'b0;

    do_instr("add",  16'hC000, 4'b0100, 1'b1, 0, 0, 0, S_WB_REG);
    do_instr("cmp",  16'hC050, 4'b0100, 1'b1, 0, 0, 0, S_WB_NONE);
    do_instr("be",   16'hB800, 4'b0000, 1'b0, 0, 0, 0, S_WB_TAKE);
    do_instr("add2", 16'hC000, 4'b1000, 1'b1, 0, 0, 0, S_WB_REG);
    run = 1'b1;  // must be ignored while busy
    do_instr("blt",  16'hB900, 4'b0000, 1'b0, 0, 0, 0, S_WB_TAKE);
    run = 1'b0;
    do_instr("ble",  16'hBA00, 4'b0000, 1'b0, 0, 0, 0, S_WB_TAKE);
    do_instr("cmp2", 16'hC050, 4'b0100, 1'b1, 0, 0, 0, S_WB_NONE);
    do_instr("bne",  16'hBB00, 4'b0000, 1'b0, 0, 0, 0, S_WB_NONE);
    do_instr("ld",   16'h0000, 4'b1111, 1'b0, 0, 1, 3, S_WB_REG);
    do_instr("st",   16'h4000, 4'b1111, 1'b0, 0, 2, 3, S_WB_NONE);
    do_instr("mov",  16'hC060, 4'b1111, 1'b0, 2, 0, 0, S_WB_REG);
    do_instr("b",    16'hA000, 4'b0000, 1'b0, 0, 0, 0, S_WB_TAKE);
    do_instr("hlt",  16'hC0F0, 4'b0000, 1'b0, 0, 0, 0, S_WB_NONE);
    cyc("halt", 3'd6, S_HALT);
    cyc("halt_hold", 3'd6, S_HALT);
    run = 1'b1;
    cyc("halt_run", 3'd6, S_HALT);
    run = 1'b0;

    // LD aborted by reset while waiting in MEM
    instr    = 16'h0000;
    alu_code = 4'b0000;
    cyc("ldr.fetch", 3'd1, S_FETCH);
    cyc("ldr.decode", 3'd2, S_BUSY);
    cyc("ldr.exec", 3'd3, S_BUSY);
    mem_ready = 1'b0;
    cyc("ldr.mem_wait", 3'd4, S_MEM_LD);
    rst_n = 1'b0;
    fl_m  = 4'b0000;
    ret_m = 16'd0;
    cyc("ldr.reset", 3'd0, S_IDLE);
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    cyc("ldr.idle1", 3'd0, S_IDLE);
    cyc("ldr.idle2", 3'd0, S_IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
